// File: rtl/final_project_soc_pio_poller.sv
// final_project_soc_pio_poller
// Avalon-MM master that periodically reads an 8-bit PIO data register and
// publishes the latest value, a change strobe and a sticky read-timeout flag.
// Only one read is outstanding at a time.
// Optional feature macro: FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN (value updates only
// after two consecutive matching captures).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for enable and period-counter expiry
// S_REQ  | avm_read asserted, held until waitrequest is low
// S_WAIT | read accepted, waiting for readdatavalid or timeout

module final_project_soc_pio_poller #(
    parameter int POLL_PERIOD = 1000,
    parameter int TIMEOUT     = 255,
    parameter int TARGET_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [7:0]  value,
    output logic        value_valid,
    output logic        changed,
    output logic        timeout_err
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PER_RELOAD = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [1:0]    ADDR       = TARGET_ADDR[1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   per_cnt_q, per_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            avm_read_q, avm_read_d;
    logic [7:0]      value_q, value_d;
    logic            value_valid_q, value_valid_d;
    logic            changed_q, changed_d;
    logic            timeout_err_q, timeout_err_d;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
    logic [7:0]      cand_q, cand_d;
    logic            cand_valid_q, cand_valid_d;
`endif

    logic [7:0]      rd_byte;
    logic [23:0]     unused_rd_hi;

    assign rd_byte      = avm_readdata[7:0];
    assign unused_rd_hi = avm_readdata[31:8];

    // Next-state, counter and capture logic
    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        to_cnt_d      = to_cnt_q;
        avm_read_d    = avm_read_q;
        value_d       = value_q;
        value_valid_d = value_valid_q;
        changed_d     = 1'b0;
        timeout_err_d = timeout_err_q;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
        cand_d        = cand_q;
        cand_valid_d  = cand_valid_q;
`endif

        // period counter runs in every state; a launch overrides it below
        if (!enable) begin
            per_cnt_d = PER_RELOAD;
        end else if (per_cnt_q != '0) begin
            per_cnt_d = per_cnt_q - PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (enable && (per_cnt_q == '0)) begin
                    state_d    = S_REQ;
                    avm_read_d = 1'b1;
                    per_cnt_d  = PER_RELOAD;
                end
            end
            S_REQ: begin
                // a request may not be withdrawn, so no timeout here
                if (!avm_waitrequest) begin
                    state_d    = S_WAIT;
                    avm_read_d = 1'b0;
                    to_cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b0;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
                    if (cand_valid_q && (rd_byte == cand_q)) begin
                        value_d       = rd_byte;
                        value_valid_d = 1'b1;
                        changed_d     = (rd_byte != value_q) || !value_valid_q;
                    end
                    cand_d       = rd_byte;
                    cand_valid_d = 1'b1;
`else
                    value_d       = rd_byte;
                    value_valid_d = 1'b1;
                    changed_d     = (rd_byte != value_q) || !value_valid_q;
`endif
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
                    cand_valid_d  = 1'b0;
`endif
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                avm_read_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            per_cnt_q     <= PER_RELOAD;
            to_cnt_q      <= '0;
            avm_read_q    <= 1'b0;
            value_q       <= 8'h00;
            value_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
            cand_q        <= 8'h00;
            cand_valid_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            to_cnt_q      <= to_cnt_d;
            avm_read_q    <= avm_read_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            changed_q     <= changed_d;
            timeout_err_q <= timeout_err_d;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
            cand_q        <= cand_d;
            cand_valid_q  <= cand_valid_d;
`endif
        end
    end

    assign avm_address = ADDR;
    assign avm_read    = avm_read_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign changed     = changed_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_final_project_soc_pio_poller.sv
// Testbench for final_project_soc_pio_poller (POLL_PERIOD=4, TIMEOUT=3,
// TARGET_ADDR=2). Expected values follow the build's debounce setting.

module tb_final_project_soc_pio_poller;

    localparam int P  = 4;
    localparam int T  = 3;
    localparam int TA = 2;
`ifdef FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic [7:0]  value;
    logic        value_valid;
    logic        changed;
    logic        timeout_err;

    int total = 0;
    int passed = 0;

    final_project_soc_pio_poller #(
        .POLL_PERIOD(P),
        .TIMEOUT    (T),
        .TARGET_ADDR(TA)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .value            (value),
        .value_valid      (value_valid),
        .changed          (changed),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         rdv;
        logic [7:0] rd;
        bit         e_read;
        logic [7:0] e_val;
        bit         e_vv;
        bit         e_ch;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(bit en, bit rdv, logic [7:0] rd, bit r,
                                logic [7:0] v, bit vv, bit ch);
        vec_t x;
        x.en = en; x.rdv = rdv; x.rd = rd;
        x.e_read = r; x.e_val = v; x.e_vv = vv; x.e_ch = ch;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic wait_read(input int max, output int n);
        n = 0;
        while (avm_read !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        // alternating 05/05/0A/0A polls, latency 1, no waitrequest
        vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[5]  = mk(1, 1, 8'h05, 0, DB ? 8'h00 : 8'h05, !DB, !DB);
        vecs[6]  = mk(1, 0, 8'h00, 0, DB ? 8'h00 : 8'h05, !DB, 0);
        vecs[7]  = mk(1, 0, 8'h00, 1, DB ? 8'h00 : 8'h05, !DB, 0);
        vecs[8]  = mk(1, 0, 8'h00, 0, DB ? 8'h00 : 8'h05, !DB, 0);
        vecs[9]  = mk(1, 1, 8'h05, 0, 8'h05, 1, DB);
        vecs[10] = mk(1, 0, 8'h00, 0, 8'h05, 1, 0);
        vecs[11] = mk(1, 0, 8'h00, 1, 8'h05, 1, 0);
        vecs[12] = mk(1, 0, 8'h00, 0, 8'h05, 1, 0);
        vecs[13] = mk(1, 1, 8'h0A, 0, DB ? 8'h05 : 8'h0A, 1, !DB);
        vecs[14] = mk(1, 0, 8'h00, 0, DB ? 8'h05 : 8'h0A, 1, 0);
        vecs[15] = mk(1, 0, 8'h00, 1, DB ? 8'h05 : 8'h0A, 1, 0);
        vecs[16] = mk(1, 0, 8'h00, 0, DB ? 8'h05 : 8'h0A, 1, 0);
        vecs[17] = mk(1, 1, 8'h0A, 0, 8'h0A, 1, DB);
        vecs[18] = mk(1, 0, 8'h00, 0, 8'h0A, 1, 0);

        // reset values
        step();
        step();
        chk("rst_read", {31'b0, avm_read}, 0);
        chk("rst_addr", {30'b0, avm_address}, TA);
        chk("rst_value", {24'b0, value}, 0);
        chk("rst_vv", {31'b0, value_valid}, 0);
        chk("rst_changed", {31'b0, changed}, 0);
        chk("rst_terr", {31'b0, timeout_err}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 19; i++) begin
            enable            = vecs[i].en;
            avm_readdatavalid = vecs[i].rdv;
            avm_readdata      = {24'hABCDEF, vecs[i].rd};
            step();
            chk($sformatf("v%0d_read", i), {31'b0, avm_read}, {31'b0, vecs[i].e_read});
            chk($sformatf("v%0d_value", i), {24'b0, value}, {24'b0, vecs[i].e_val});
            chk($sformatf("v%0d_vv", i), {31'b0, value_valid}, {31'b0, vecs[i].e_vv});
            chk($sformatf("v%0d_changed", i), {31'b0, changed}, {31'b0, vecs[i].e_ch});
            chk($sformatf("v%0d_terr", i), {31'b0, timeout_err}, 0);
        end
        avm_readdatavalid = 1'b0;

        // waitrequest high for 7 read cycles: read stays high 8 cycles
        avm_waitrequest = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (avm_read !== 1'b1 || avm_address !== 2'(TA) || timeout_err !== 1'b0) ok = 1'b0;
        end
        chk("wr_hold_read_addr", {31'b0, ok}, 1);
        avm_waitrequest = 1'b0;
        step();
        chk("wr_accept_read_low", {31'b0, avm_read}, 0);

        // no response: timeout at 3rd edge after WAIT entry
        step();
        chk("to_edge1", {31'b0, timeout_err}, 0);
        step();
        chk("to_edge2", {31'b0, timeout_err}, 0);
        step();
        chk("to_edge3", {31'b0, timeout_err}, 1);
        chk("to_value_kept", {24'b0, value}, 8'h0A);

        // late/stray valid while idle is ignored
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h77;
        step();
        avm_readdatavalid = 1'b0;
        chk("stray_value", {24'b0, value}, 8'h0A);
        chk("stray_terr", {31'b0, timeout_err}, 1);
        chk("stray_launch", {31'b0, avm_read}, 1);
        step();
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h11;
        step();
        avm_readdatavalid = 1'b0;
        chk("rec_value", {24'b0, value}, DB ? 8'h0A : 8'h11);
        chk("rec_terr", {31'b0, timeout_err}, 0);
        chk("rec_changed", {31'b0, changed}, DB ? 0 : 1);

        // enable drops while in WAIT
        wait_read(10, n);
        chk("en_drop_launch_seen", {31'b0, avm_read}, 1);
        step();
        enable = 1'b0;
        step();
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h22;
        step();
        avm_readdatavalid = 1'b0;
        chk("en_drop_value", {24'b0, value}, DB ? 8'h0A : 8'h22);
        chk("en_drop_changed", {31'b0, changed}, DB ? 0 : 1);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (avm_read !== 1'b0) ok = 1'b0;
        end
        chk("en_drop_no_read", {31'b0, ok}, 1);
        avm_waitrequest = 1'b1;
        enable = 1'b1;
        wait_read(20, n);
        chk("en_rise_latency", n, P);

        // reset asserted during REQ
        step();
        step();
        chk("req_held", {31'b0, avm_read}, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        chk("rreq_read", {31'b0, avm_read}, 0);
        chk("rreq_value", {24'b0, value}, 0);
        chk("rreq_vv", {31'b0, value_valid}, 0);
        chk("rreq_changed", {31'b0, changed}, 0);
        chk("rreq_terr", {31'b0, timeout_err}, 0);
        chk("rreq_addr", {30'b0, avm_address}, TA);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h33;
        step();
        avm_readdatavalid = 1'b0;
        chk("rreq_inflight_ignored", {24'b0, value}, 0);
        chk("rreq_inflight_vv", {31'b0, value_valid}, 0);
        wait_read(20, n);
        chk("rreq_relaunch", n, P - 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/final_project_soc_pio_poller.md
# final_project_soc_pio_poller

Avalon-MM master that periodically reads the data register of an 8-bit input PIO slave (e.g. a player-direction port) and publishes the latest value to game logic. It provides a `changed` strobe and flags a read timeout. It sits between the Qsys interconnect (master side) and fabric logic that needs PIO inputs without a CPU in the loop. One read is outstanding at a time.

## Interface

Parameters:
- `POLL_PERIOD`, default 1000: cycles between poll launches; legal range ≥ 2.
- `TIMEOUT`, default 255: maximum cycles to wait for `avm_readdatavalid` after the read is accepted; legal range ≥ 1.
- `TARGET_ADDR`, default 0: word address driven on `avm_address`; this is the PIO data register.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  high = polling allowed.
- `avm_address`  out  2  constant `TARGET_ADDR`.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave/interconnect stall.
- `avm_readdata`  in  32  read data; only bits [7:0] are used.
- `avm_readdatavalid`  in  1  read data valid.
- `value`  out  8  last accepted PIO value.
- `value_valid`  out  1  set after the first accepted value; sticky until reset.
- `changed`  out  1  one-cycle pulse when `value` is updated with new content.
- `timeout_err`  out  1  sticky; cleared by reset or by the next accepted value.

## Operation

- FSM states:
  - IDLE: waits for `enable` and period-counter expiry.
  - REQ: `avm_read`=1.
  - WAIT: awaits `avm_readdatavalid`.
- Period counter:
  - While `enable`=0 it reloads to `POLL_PERIOD-1`.
  - While `enable`=1 it decrements by 1 per cycle, saturating at 0.
  - IDLE→REQ when the counter is 0 and `enable`=1. The counter reloads on that same edge.
- REQ:
  - `avm_read` is held until the first cycle with `avm_waitrequest`=0.
  - That cycle is the accept cycle; the FSM goes to WAIT on the next edge.
  - There is no timeout in REQ, because Avalon forbids withdrawing a request.
- WAIT:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - If `avm_readdatavalid`=1, the block captures `avm_readdata[7:0]` and goes to IDLE.
  - If the counter reaches `TIMEOUT` without valid data, `timeout_err` is set, the FSM goes to IDLE, and `value` is unchanged.
- Capture:
  - `value` is updated and `value_valid` is set to 1.
  - `changed` pulses if the new data ≠ the old `value`, or if this is the first capture since reset.
  - `timeout_err` is cleared.
- `avm_readdatavalid` outside WAIT is ignored. This covers late data after a timeout.
- If `enable` falls mid-transaction, the current transaction completes normally and no new poll launches.
- Reset in any state: the FSM returns to IDLE and `avm_read` drops on the next edge. An in-flight response is then ignored.

## Timing

- Reset values:
  - `avm_read`=0, `avm_address`=`TARGET_ADDR`.
  - `value`=0, `value_valid`=0, `changed`=0, `timeout_err`=0.
  - FSM in IDLE, period counter = `POLL_PERIOD-1`.
- If `enable` is sampled high at edge k after being low, `avm_read` goes high after edge k+`POLL_PERIOD`-1.
- With zero waitrequest, consecutive poll launches are exactly `POLL_PERIOD` cycles apart, provided each response arrives in fewer than `POLL_PERIOD`-1 cycles. Otherwise the next launch waits for IDLE.
- Capture latency: `value`/`changed` are updated at the edge where `avm_readdatavalid` is sampled high, visible the following cycle. `changed` is high for exactly one cycle.
- Timeout: if no response arrives, `timeout_err` rises at edge `TIMEOUT` after WAIT entry.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- `FINAL_PROJECT_SOC_PIO_DEBOUNCE_EN` defined:
  - Each capture is stored in a candidate register.
  - `value` updates only when the capture equals the previous capture. A capture is the first in a matching pair only if the previous transaction did not time out; a timeout clears the candidate.
  - `value_valid` requires two matching consecutive captures.
  - `changed` pulses only on a `value` update with different content, or on the first update.
- Macro undefined: every capture updates `value` directly, as described in Operation. No candidate register is instantiated.

## Test plan

- Reset, then `enable`=1 with `POLL_PERIOD`=4, no waitrequest, response latency 1, slave returns 0x05: the first read launches 4 cycles after enable, `value`=0x05, `value_valid`=1, `changed` pulses once.
- Slave alternates 0x05/0x05/0x0A on successive polls: `changed` pulses only on the 0x0A capture. Without debounce, `value`=0x0A after the third poll. With debounce, `value` stays 0x05 until 0x0A is read twice.
- `avm_waitrequest` held high for 7 cycles: `avm_read` stays high for 8 cycles, `avm_address`=`TARGET_ADDR` stays stable, and no timeout fires.
- With `TIMEOUT`=3, no `avm_readdatavalid` is returned: `timeout_err`=1 at the 3rd edge after WAIT entry and `value` is unchanged. A later valid response of 0x11 clears `timeout_err` and updates `value`. A stray `avm_readdatavalid` in IDLE is ignored.
- `enable` drops while in WAIT: the response 0x22 is still captured and no further `avm_read` occurs. When `enable` rises again, the first read comes `POLL_PERIOD` cycles later.
- `reset` asserted during REQ: `avm_read`=0 and all outputs are at their reset values the next cycle.
